mmio_bridge: RTL and testbench

MMIO_BRIDGE -- requirements
Module: mmio_bridge

---
 rtl/mmio_bridge_pkg.sv | 20 ++
 rtl/mmio_bridge_timeout_cnt.sv | 30 +++
 rtl/mmio_bridge.sv | 134 +++++++++++++
 tb/tb_mmio_bridge.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_bridge_pkg.sv
// Shared MMIO definitions: bridge state encoding, window/timeout defaults and
// the legal-address rule.
package mmio_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2,
      ST_ERR  = 2'd3
   } mmio_state_t;

   localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
   localparam logic [15:0] MMIO_HI_DEF        = 16'hFFFF;

   // Word aligned and inside the 64 KiB MMIO window selected by hi.
   function automatic logic addr_is_legal(input logic [31:0] addr, input logic [15:0] hi);
      return (addr[1:0] == 2'b00) && (addr[31:16] == hi);
   endfunction

endpackage

// File: rtl/mmio_bridge_timeout_cnt.sv
// Bus-wait counter: counts stalled BUS cycles and flags the terminal count
// LIMIT-1 so the bridge can abandon a device that never answers.
module mmio_timeout_cnt #(
   parameter int unsigned LIMIT = 255
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0] TERM = CW'(LIMIT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != TERM)) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == TERM);

endmodule

// File: rtl/mmio_bridge.sv
// CPU-to-MMIO bridge: accepts one access at a time, checks the address,
// runs the device handshake with a timeout and returns a one-cycle response.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  ST_IDLE | ready for a request; cpu_ready high
//  ST_BUS  | device strobe active, waiting for mmio_done or timeout
//  ST_RESP | one-cycle good response, cpu_err low
//  ST_ERR  | one-cycle error response (bad address or timeout)
module mmio_bridge
   import mmio_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter logic [15:0] MMIO_HI        = MMIO_HI_DEF
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_ready,
   output logic        cpu_resp_valid,
   output logic [31:0] cpu_rdata,
   output logic        cpu_err,
   output logic        mmio_read,
   output logic        mmio_write,
   output logic [31:0] mmio_addr,
   output logic [31:0] mmio_write_data,
   input  logic        mmio_done,
   input  logic [31:0] mmio_read_data
);

   mmio_state_t state, state_nxt;
   logic        we_q;
   logic [31:0] rdata_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        tmr_clear;
   logic        tmr_en;
   logic        tmr_expired;
   logic        accept;
   logic        legal;

   assign accept = (state == ST_IDLE) && cpu_req;
   assign legal  = addr_is_legal(cpu_addr, MMIO_HI);

   mmio_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .sys_clk (sys_clk),
      .rst     (rst),
      .clear   (tmr_clear),
      .enable  (tmr_en),
      .expired (tmr_expired)
   );

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cpu_ready      = 1'b0;
      cpu_resp_valid = 1'b0;
      cpu_err        = 1'b0;
      mmio_read      = 1'b0;
      mmio_write     = 1'b0;
      tmr_clear      = 1'b0;
      tmr_en         = 1'b0;
      unique case (state)
         ST_IDLE: begin
            cpu_ready = 1'b1;
            if (cpu_req) begin
               tmr_clear = 1'b1;
               state_nxt = legal ? ST_BUS : ST_ERR;
            end
         end
         ST_BUS: begin
            mmio_read  = ~we_q;
            mmio_write = we_q;
            // A completion on the terminal cycle still counts as success.
            if (mmio_done) begin
               state_nxt = ST_RESP;
            end else begin
               tmr_en = 1'b1;
               if (tmr_expired) begin
                  state_nxt = ST_ERR;
               end
            end
         end
         ST_RESP: begin
            cpu_resp_valid = 1'b1;
            state_nxt      = ST_IDLE;
         end
         ST_ERR: begin
            cpu_resp_valid = 1'b1;
            cpu_err        = 1'b1;
            state_nxt      = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Device address/data only move on a legal accept so the bus side holds
   // its last values through error responses. Read data is zeroed at accept,
   // which also covers both error paths.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         we_q    <= 1'b0;
         rdata_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         if (accept) begin
            we_q    <= cpu_we;
            rdata_q <= '0;
            if (legal) begin
               addr_q  <= cpu_addr;
               wdata_q <= cpu_wdata;
            end
         end else if ((state == ST_BUS) && mmio_done) begin
            rdata_q <= we_q ? 32'h0 : mmio_read_data;
         end
      end
   end

   assign cpu_rdata       = rdata_q;
   assign mmio_addr       = addr_q;
   assign mmio_write_data = wdata_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed cases followed by random
// accesses scored against a transaction-level reference model.
module tb_mmio_bridge;

   localparam int T = 8;

   logic        sys_clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_ready;
   logic        cpu_resp_valid;
   logic [31:0] cpu_rdata;
   logic        cpu_err;
   logic        mmio_read;
   logic        mmio_write;
   logic [31:0] mmio_addr;
   logic [31:0] mmio_write_data;
   logic        mmio_done;
   logic [31:0] mmio_read_data;

   int n_cmp = 0;
   int n_bad = 0;

   int          dev_cyc = 0;
   int          dev_delay = 0;
   logic [31:0] dev_data = 32'h0;
   int          n_rd = 0;
   int          n_wr = 0;
   logic [31:0] a0 = 32'h0;
   logic [31:0] d0 = 32'h0;
   bit          unstable = 1'b0;

   always #5 sys_clk = ~sys_clk;

   mmio_bridge #(.TIMEOUT_CYCLES(T), .MMIO_HI(16'hFFFF)) dut (
      .sys_clk         (sys_clk),
      .rst             (rst),
      .cpu_req         (cpu_req),
      .cpu_we          (cpu_we),
      .cpu_addr        (cpu_addr),
      .cpu_wdata       (cpu_wdata),
      .cpu_ready       (cpu_ready),
      .cpu_resp_valid  (cpu_resp_valid),
      .cpu_rdata       (cpu_rdata),
      .cpu_err         (cpu_err),
      .mmio_read       (mmio_read),
      .mmio_write      (mmio_write),
      .mmio_addr       (mmio_addr),
      .mmio_write_data (mmio_write_data),
      .mmio_done       (mmio_done),
      .mmio_read_data  (mmio_read_data)
   );

   // Device model: answers on the (dev_delay+1)-th strobe cycle and records
   // how many strobe cycles it saw and whether address/data stayed put.
   always @(negedge sys_clk) begin
      if (mmio_read || mmio_write) begin
         dev_cyc = dev_cyc + 1;
         if (mmio_read)  n_rd = n_rd + 1;
         if (mmio_write) n_wr = n_wr + 1;
         if (dev_cyc == 1) begin
            a0 = mmio_addr;
            d0 = mmio_write_data;
         end else if ((mmio_addr !== a0) || (mmio_write_data !== d0)) begin
            unstable = 1'b1;
         end
         mmio_done      = (dev_cyc == dev_delay + 1);
         mmio_read_data = mmio_done ? dev_data : $urandom;
      end else begin
         dev_cyc        = 0;
         mmio_done      = 1'b0;
         mmio_read_data = $urandom;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Transaction-level expectation derived from the address rule, the device
   // answer delay and the timeout limit.
   function automatic void model(input bit we, input logic [31:0] addr, input int delay,
                                 input logic [31:0] data, output int lat, output int strobes,
                                 output bit err, output logic [31:0] rdata);
      if ((addr[1:0] != 2'b00) || (addr[31:16] != 16'hFFFF)) begin
         lat = 1; strobes = 0; err = 1'b1; rdata = 32'h0;
      end else if (delay + 1 <= T) begin
         strobes = delay + 1; lat = strobes + 1; err = 1'b0;
         rdata = we ? 32'h0 : data;
      end else begin
         strobes = T; lat = T + 1; err = 1'b1; rdata = 32'h0;
      end
   endfunction

   task automatic do_txn(input string tag, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] data,
                         input int delay, input bit keep_req);
      int          lat_e, str_e, k;
      bit          err_e;
      logic [31:0] rd_e;
      model(we, addr, delay, data, lat_e, str_e, err_e, rd_e);
      @(negedge sys_clk);
      check({tag, ".ready"}, 32'(cpu_ready), 32'd1);
      check({tag, ".idle_resp"}, 32'(cpu_resp_valid), 32'd0);
      dev_delay = delay;
      dev_data  = data;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      @(posedge sys_clk);
      #1;
      n_rd = 0; n_wr = 0; unstable = 1'b0;
      if (!keep_req) begin
         cpu_req   = 1'b0;
         cpu_we    = 1'($urandom);
         cpu_addr  = $urandom;
         cpu_wdata = $urandom;
      end
      k = 0;
      do begin
         @(negedge sys_clk);
         k++;
      end while (!cpu_resp_valid && k < 40);
      check({tag, ".latency"}, 32'(k), 32'(lat_e));
      check({tag, ".err"}, 32'(cpu_err), 32'(err_e));
      check({tag, ".rdata"}, cpu_rdata, rd_e);
      check({tag, ".n_read"}, 32'(n_rd), we ? 32'd0 : 32'(str_e));
      check({tag, ".n_write"}, 32'(n_wr), we ? 32'(str_e) : 32'd0);
      check({tag, ".strobe_at_resp"}, 32'({mmio_read, mmio_write}), 32'd0);
      if (str_e > 0) begin
         check({tag, ".stable"}, 32'(unstable), 32'd0);
         check({tag, ".mmio_addr"}, a0, addr);
         check({tag, ".mmio_wdata"}, d0, wdata);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] hi, lo;
      int          resp_seen, sel;
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      check("rst.resp_valid", 32'(cpu_resp_valid), 32'd0);
      check("rst.err", 32'(cpu_err), 32'd0);
      check("rst.rdata", cpu_rdata, 32'h0);
      check("rst.strobes", 32'({mmio_read, mmio_write}), 32'd0);
      check("rst.mmio_addr", mmio_addr, 32'h0);
      check("rst.mmio_wdata", mmio_write_data, 32'h0);
      rst = 1'b0;

      do_txn("load_fast", 1'b0, 32'hFFFF_0000, 32'h0, 32'h00AB_CDEF, 0, 1'b0);
      do_txn("store_slow", 1'b1, 32'hFFFF_0080, 32'h0000_0055, $urandom, 3, 1'b0);
      do_txn("bad_window", 1'b0, 32'h0000_1000, $urandom, $urandom, 0, 1'b0);
      check("bad.mmio_addr_held", mmio_addr, 32'hFFFF_0080);
      do_txn("bad_align", 1'b0, 32'hFFFF_0002, $urandom, $urandom, 0, 1'b0);
      do_txn("timeout", 1'b0, 32'hFFFF_0010, $urandom, $urandom, 50, 1'b0);
      do_txn("done_at_limit", 1'b1, 32'hFFFF_0014, $urandom, $urandom, T - 1, 1'b0);
      do_txn("done_before_limit", 1'b0, 32'hFFFF_0018, $urandom, $urandom, T - 2, 1'b0);

      // Reset during the second BUS cycle aborts the access silently.
      @(negedge sys_clk);
      dev_delay = 100;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hFFFF_0040; cpu_wdata = $urandom;
      @(posedge sys_clk);
      #1;
      cpu_req = 1'b0;
      n_rd = 0; n_wr = 0;
      @(negedge sys_clk);
      @(negedge sys_clk);
      check("rst_bus.strobe_before", 32'(mmio_read), 32'd1);
      rst = 1'b1;
      @(posedge sys_clk);
      #1;
      check("rst_bus.strobes_dropped", 32'({mmio_read, mmio_write}), 32'd0);
      check("rst_bus.mmio_addr", mmio_addr, 32'h0);
      @(negedge sys_clk);
      rst = 1'b0;
      resp_seen = 0;
      repeat (4) begin
         @(negedge sys_clk);
         if (cpu_resp_valid) resp_seen++;
      end
      check("rst_bus.no_resp", 32'(resp_seen), 32'd0);
      check("rst_bus.n_read", 32'(n_rd), 32'd2);
      do_txn("after_rst", 1'b0, 32'hFFFF_0100, $urandom, $urandom, 1, 1'b0);

      // cpu_req held high across three back-to-back requests.
      do_txn("b2b0", 1'b0, 32'hFFFF_0200, $urandom, $urandom, 0, 1'b1);
      do_txn("b2b1", 1'b1, 32'hFFFF_0204, $urandom, $urandom, 2, 1'b1);
      do_txn("b2b2", 1'b0, 32'h1234_0208, $urandom, $urandom, 0, 1'b1);
      cpu_req = 1'b0;

      for (int i = 0; i < 30; i++) begin
         sel = $urandom_range(0, 3);
         lo  = 16'($urandom);
         hi  = 16'hFFFF;
         if (sel < 2) lo[1:0] = 2'b00;
         else if (sel == 2) begin
            if (lo[1:0] == 2'b00) lo[1:0] = 2'b01;
         end else begin
            hi = 16'($urandom);
            if (hi == 16'hFFFF) hi = 16'h1234;
         end
         do_txn("rand", 1'($urandom), {hi, lo}, $urandom, $urandom,
                $urandom_range(0, T + 2), 1'($urandom_range(0, 1)));
      end
      cpu_req = 1'b0;
      @(negedge sys_clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
